// File: rtl/sar_conv_seq.sv
// Successive-approximation conversion sequencer.
// Once per PERIOD cycles (while en is high) it tracks the input for SAMPLE_CYC
// cycles. It then binary-searches NBITS bits. Each bit uses a STROBE cycle that
// fires the comparator on a trial code, followed by a DECIDE cycle that keeps
// the comparator's answer. Finally it publishes the result for one DONE cycle.
//
// Output timing relative to cycle 0 (the tick cycle, state IDLE):
//   sample_o      cycles 1..SAMPLE_CYC
//   cmp_strobe_o  cycle SAMPLE_CYC+1+2j for bit j (j=0 is the MSB)
//   data_valid_o  cycle SAMPLE_CYC+2*NBITS+1
// cmp_i is only looked at on the rising edge that ends a DECIDE cycle.
module sar_conv_seq #(
    parameter int NBITS      = 10,
    parameter int SAMPLE_CYC = 4,
    parameter int PERIOD     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cmp_i,
    output logic             sample_o,
    output logic [NBITS-1:0] dac_o,
    output logic             cmp_strobe_o,
    output logic [NBITS-1:0] data_o,
    output logic             data_valid_o,
    output logic             busy_o,
    output logic             missed_o
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    localparam logic [PW-1:0]    PCNT_LAST = PW'(PERIOD - 1);
    localparam logic [KW-1:0]    K_MSB     = KW'(NBITS - 1);
    localparam logic [SW-1:0]    SCNT_LOAD = SW'(SAMPLE_CYC - 1);
    localparam logic [NBITS-1:0] ONE_CODE  = NBITS'(1);
    localparam logic [NBITS-1:0] MSB_CODE  = ONE_CODE << (NBITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        STROBE = 1'b0,
        DECIDE = 1'b1
    } phase_t;

    state_t           state;
    phase_t           phase;
    logic [PW-1:0]    pcnt;
    logic [SW-1:0]    scnt;
    logic [KW-1:0]    k;
    logic [NBITS-1:0] result;
    logic             tick;

    // Values used at the end of a DECIDE cycle: the result with bit k set to
    // the comparator answer, and the trial code for the next lower bit.
    logic [NBITS-1:0] res_upd;
    logic [KW-1:0]    k_dn;
    logic [NBITS-1:0] trial_next;

    assign tick     = en && (pcnt == '0);
    // A tick that arrives mid-conversion is dropped; this flags it in the same cycle.
    assign missed_o = tick && (state != IDLE);

    // Free-running period counter; held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!en || pcnt == PCNT_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Merge the comparator decision into the result and form the next trial code.
    always_comb begin
        res_upd    = result;
        res_upd[k] = cmp_i;
        k_dn       = k - 1'b1;
        trial_next = res_upd | (ONE_CODE << k_dn);
    end

    // Conversion FSM with registered analog-facing and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= STROBE;
            scnt         <= '0;
            k            <= '0;
            result       <= '0;
            sample_o     <= 1'b0;
            dac_o        <= '0;
            cmp_strobe_o <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
        end else if (!en) begin
            // Abort: drop back to idle; data_o keeps the last good result.
            state        <= IDLE;
            phase        <= STROBE;
            sample_o     <= 1'b0;
            dac_o        <= '0;
            cmp_strobe_o <= 1'b0;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_valid_o <= 1'b0;
                    cmp_strobe_o <= 1'b0;
                    dac_o        <= '0;
                    if (tick) begin
                        state    <= SAMPLE;
                        scnt     <= SCNT_LOAD;
                        result   <= '0;
                        sample_o <= 1'b1;
                        busy_o   <= 1'b1;
                    end else begin
                        sample_o <= 1'b0;
                        busy_o   <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (scnt == '0) begin
                        state        <= CONV;
                        phase        <= STROBE;
                        k            <= K_MSB;
                        sample_o     <= 1'b0;
                        dac_o        <= MSB_CODE;
                        cmp_strobe_o <= 1'b1;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                CONV: begin
                    if (phase == STROBE) begin
                        phase        <= DECIDE;
                        cmp_strobe_o <= 1'b0;
                    end else begin
                        result <= res_upd;
                        if (k == '0) begin
                            state        <= DONE;
                            dac_o        <= res_upd;
                            data_o       <= res_upd;
                            data_valid_o <= 1'b1;
                        end else begin
                            phase        <= STROBE;
                            k            <= k_dn;
                            dac_o        <= trial_next;
                            cmp_strobe_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    dac_o        <= '0;
                    data_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_conv_seq.sv
// Directed bench for sar_conv_seq: table of conversions with an ideal
// comparator, plus abort, async reset and illegal-PERIOD sequences.
module tb_sar_conv_seq;

    localparam int NB = 10;
    localparam int S  = 4;
    localparam int P  = 32;
    localparam int NV = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (legal PERIOD).
    logic          rst_n;
    logic          en;
    logic          cmp = 1'b0;
    logic          sample, strobe, valid, busy, missed;
    logic [NB-1:0] dac, data;

    // Second instance with a PERIOD that is too short.
    logic          b_en;
    logic          b_cmp = 1'b0;
    logic          b_sample, b_strobe, b_valid, b_busy, b_missed;
    logic [NB-1:0] b_dac, b_data;

    sar_conv_seq #(.NBITS(NB), .SAMPLE_CYC(S), .PERIOD(P)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmp_i(cmp),
        .sample_o(sample), .dac_o(dac), .cmp_strobe_o(strobe),
        .data_o(data), .data_valid_o(valid), .busy_o(busy), .missed_o(missed)
    );

    sar_conv_seq #(.NBITS(NB), .SAMPLE_CYC(S), .PERIOD(20)) u_bad (
        .clk(clk), .rst_n(rst_n), .en(b_en), .cmp_i(b_cmp),
        .sample_o(b_sample), .dac_o(b_dac), .cmp_strobe_o(b_strobe),
        .data_o(b_data), .data_valid_o(b_valid), .busy_o(b_busy), .missed_o(b_missed)
    );

    // Ideal comparator: answers vin >= last strobed code during the DECIDE
    // cycle; with noise on it toggles randomly in every other cycle.
    logic [NB-1:0] vin;
    logic          noise;
    logic [NB-1:0] code = '0;
    logic          dec = 1'b0;
    logic [NB-1:0] b_vin;
    logic [NB-1:0] b_code = '0;

    always @(posedge clk) begin
        dec <= strobe;
        if (strobe) code <= dac;
        if (b_strobe) b_code <= b_dac;
    end

    always @(negedge clk) begin
        cmp   = (noise && !dec) ? 1'($urandom_range(0, 1)) : (vin >= code);
        b_cmp = (b_vin >= b_code);
    end

    int            n_vec = 0;
    int            n_err = 0;
    logic [NB-1:0] exp_data;

    typedef struct {
        logic [NB-1:0] vin;
        logic          noise;
        logic [NB-1:0] exp;
    } vec_t;
    vec_t tbl[NV];

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
        end
    endtask

    // Expected {sample, strobe, busy, valid, dac} for cycle cc of a period.
    function automatic logic [NB+3:0] exp_ctl(input int cc, input logic [NB-1:0] v);
        logic          s, st, b, dv;
        logic [NB-1:0] d, hi;
        int            bit_i;
        s = 1'b0; st = 1'b0; b = 1'b0; dv = 1'b0; d = '0;
        if (cc >= 1 && cc <= S) begin
            s = 1'b1;
            b = 1'b1;
        end else if (cc >= S + 1 && cc <= S + 2 * NB) begin
            bit_i = NB - 1 - (cc - S - 1) / 2;
            hi    = (v >> (bit_i + 1)) << (bit_i + 1);
            d     = hi | (NB'(1) << bit_i);
            st    = ((cc - S - 1) % 2 == 0);
            b     = 1'b1;
        end else if (cc == S + 2 * NB + 1) begin
            dv = 1'b1;
            b  = 1'b1;
            d  = v;
        end
        return {s, st, b, dv, d};
    endfunction

    // Run cycles c0..n-1 of a conversion (cycle 0 = the current cycle), checking every cycle.
    task automatic run_conv(input logic [NB-1:0] v, input logic nz, input logic [NB-1:0] expd,
                            input int c0, input int n);
        int cc;
        vin   = v;
        noise = nz;
        en    = 1'b1;
        for (int c = c0; c < n; c++) begin
            cc = c % P;
            if (cc == S + 2 * NB + 1) exp_data = expd;
            check("ctl", c, {missed, sample, strobe, busy, valid, dac}, {1'b0, exp_ctl(cc, v)});
            check("data", c, data, exp_data);
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0] = '{10'h2AB, 1'b0, 10'h2AB};
        tbl[1] = '{10'h000, 1'b0, 10'h000};
        tbl[2] = '{10'h3FF, 1'b0, 10'h3FF};
        tbl[3] = '{10'h155, 1'b1, 10'h155};
        tbl[4] = '{10'h2AB, 1'b1, 10'h2AB};
        tbl[5] = '{10'h200, 1'b1, 10'h200};

        rst_n    = 1'b0;
        en       = 1'b0;
        b_en     = 1'b0;
        vin      = '0;
        b_vin    = '0;
        noise    = 1'b0;
        exp_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 0, {missed, sample, strobe, busy, valid, dac, data}, 0);
        check("rst_bad", 0, {b_missed, b_sample, b_strobe, b_busy, b_valid, b_dac, b_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two full periods per vector: valid at cycles 25 and 57.
        for (int i = 0; i < NV; i++) begin
            run_conv(tbl[i].vin, tbl[i].noise, tbl[i].exp, 0, 2 * P);
            en = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Abort in cycle 12 (mid-CONV), then restart with cycle-0 timing.
        run_conv(10'h1C7, 1'b1, 10'h1C7, 0, 12);
        en = 1'b0;
        for (int c = 13; c < 30; c++) begin
            @(negedge clk);
            check("abort_ctl", c, {missed, sample, strobe, busy, valid, dac}, 0);
            check("abort_data", c, data, exp_data);
        end
        @(negedge clk);
        run_conv(10'h1C7, 1'b0, 10'h1C7, 0, 30);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of SAMPLE, released with en high.
        run_conv(10'h0F0, 1'b0, 10'h0F0, 0, 3);
        #1 rst_n = 1'b0;
        #1;
        exp_data = '0;
        check("async_rst", 3, {missed, sample, strobe, busy, valid, dac, data}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_conv(10'h0F0, 1'b0, 10'h0F0, 1, 30);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // PERIOD=20: tick at cycle 20 lands mid-conversion and is reported.
        b_vin = 10'h19C;
        b_en  = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            check("bad_ctl", c, {b_missed, b_valid, b_busy},
                  {(c == 20), (c == 25), (c >= 1 && c <= 25)});
            if (c == 25) check("bad_data", c, b_data, 10'h19C);
            @(negedge clk);
        end
        check("bad_hold", 41, b_data, 10'h19C);
        b_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_conv_seq.md
# sar_conv_seq

Successive-approximation conversion sequencer for the mixed-signal front end. It runs on the 3.2 MHz digital clock and sequences one analog conversion per programmed period: sample phase, then bit-by-bit DAC trial codes with comparator strobes, then a result word. It sits between the digital core and the analog comparator/capacitive-DAC macro, which latches on the phase-shifted comparator clock. The core gates conversions with `en`.

## Interface
- `NBITS`, 10: conversion resolution in bits.
- `SAMPLE_CYC`, 4: number of cycles `sample_o` is held high; must be ≥1.
- `PERIOD`, 32: conversion period in `clk` cycles; must be ≥ `SAMPLE_CYC`+2·`NBITS`+2.

- `clk`  in  1  digital clock (3.2 MHz), rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  conversion enable; low = idle and period counter cleared.
- `cmp_i`  in  1  comparator decision: 1 = input ≥ DAC code. Valid in the cycle after `cmp_strobe_o`.
- `sample_o`  out  1  track/hold switch control: 1 = track.
- `dac_o`  out  NBITS  trial code to the capacitive DAC.
- `cmp_strobe_o`  out  1  one-cycle comparator trigger.
- `data_o`  out  NBITS  last completed conversion result.
- `data_valid_o`  out  1  one-cycle pulse; `data_o` is new this cycle.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `missed_o`  out  1  one-cycle pulse: a period tick arrived while busy.

## Operation
- Period counter `pcnt`, width `$clog2(PERIOD)`:
  - Held at 0 while `en`=0.
  - Otherwise increments and wraps from `PERIOD`-1 to 0.
  - `tick` = `en` & (`pcnt`==0), combinational.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE → SAMPLE on `tick`. Load the sample counter and clear the result register.
- SAMPLE:
  - `sample_o`=1 and `dac_o`=0 for `SAMPLE_CYC` cycles.
  - Then go to CONV with bit index `k`=`NBITS`-1 and phase=STROBE.
- CONV alternates two phases per bit:
  - STROBE: `dac_o` = result | (1<<k), `cmp_strobe_o`=1.
  - DECIDE: `dac_o` unchanged, `cmp_strobe_o`=0. At the end of the cycle, bit k of the result = `cmp_i`.
  - After DECIDE with k=0, go to DONE. Otherwise decrement k and return to STROBE.
- DONE (one cycle):
  - `data_o` ← final result, `data_valid_o`=1, `dac_o` = final result.
  - Then go to IDLE.
- `tick` while state ≠ IDLE: `missed_o`=1 for that cycle, tick discarded, counter unaffected.
- `en`=0 in any state:
  - Next state is IDLE and the period counter clears.
  - No `data_valid_o` for the aborted conversion; `data_o` keeps its previous value.
- `sample_o`, `cmp_strobe_o` and `dac_o` are registered (state-decoded from registers) and glitch-free. `dac_o`=0 in IDLE and SAMPLE.
- `data_o` holds until the next DONE.

## Timing
- Reset values: state IDLE, `pcnt`=0, and all outputs 0 (`sample_o`, `dac_o`, `cmp_strobe_o`, `data_o`, `data_valid_o`, `busy_o`, `missed_o`).
- Cycle 0 is the first cycle with `en`=1 (tick; state IDLE).
- `sample_o` is high in cycles 1..S, where S=`SAMPLE_CYC`.
- Bit j (j=0 for MSB) is strobed in cycle S+1+2j and decided at the end of cycle S+2+2j.
- `data_valid_o` is high in cycle S+2·`NBITS`+1; with default parameters that is cycle 25.
- The next tick is at cycle `PERIOD` (32), and the state is already IDLE.
- `cmp_i` is sampled only at the rising edge ending a DECIDE cycle. It is ignored in all other cycles.
- `rst_n` asserted mid-operation: immediate return to reset values, including `data_o`=0.
- `tick` and DONE in the same cycle cannot occur for legal `PERIOD`. If `PERIOD` is violated, the tick is reported via `missed_o`.

## Test plan
- Reset then `en`=1, with a comparator model where `cmp_i` = (vin ≥ last strobed `dac_o`), vin=0x2AB:
  - `sample_o` high in cycles 1–4.
  - Strobes in cycles 5,7,…,23.
  - `data_valid_o` in cycle 25 with `data_o`=0x2AB.
  - Second `data_valid_o` in cycle 57.
- Endpoints: vin=0x000 → `data_o`=0x000; vin=0x3FF → `data_o`=0x3FF. Trial codes for vin=0x3FF are 0x200, 0x300, …, 0x3FF.
- Drop `en` in cycle 12 (mid-CONV):
  - `busy_o`=0 and `dac_o`=0 from the next cycle.
  - No `data_valid_o`; `data_o` keeps its prior value.
  - Re-raising `en` restarts at cycle 0 timing.
- Assert `rst_n`=0 asynchronously mid-SAMPLE: all outputs go to 0 without waiting for a clock edge. After release with `en`=1, the first tick occurs on the first cycle.
- Instantiate with `PERIOD`=20 (illegal): `missed_o` pulses at cycle 20 while busy, and the conversion still completes with a correct `data_o`.
- Toggle `cmp_i` randomly outside DECIDE cycles: the result is unaffected.
